// File: rtl/ex_mem_if.sv
// ex_mem_if: ID/EX bundle into the execute stage, plus its stall/branch/npc feedback
interface ex_mem_if;
    logic        running, WEn, RFWr, stall, branch;
    logic [1:0]  NPCop, WDSel;
    logic [3:0]  ALUop;
    logic [31:0] PC, A, B, rD2, ext, rR1, rR2, wR, npc;
    modport master (
        output running, NPCop, WEn, RFWr, WDSel, ALUop, PC, A, B, rD2, ext, rR1, rR2, wR,
        input  stall, branch, npc
    );
    modport slave (
        input  running, NPCop, WEn, RFWr, WDSel, ALUop, PC, A, B, rD2, ext, rR1, rR2, wR,
        output stall, branch, npc
    );
endinterface

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute stage + EX/MEM register; define EX_FWD_EN for operand forwarding, else hazards stall
module ex_mem_stage (
    input  logic        clk,
    input  logic        rst,
    ex_mem_if.slave     id,
    input  logic        wb_RFWr,
    input  logic [4:0]  wb_wR,
    input  logic [31:0] wb_wD,
    output logic        m_running,
    output logic        m_WEn,
    output logic        m_RFWr,
    output logic [1:0]  m_WDSel,
    output logic [4:0]  m_wR,
    output logic [31:0] m_PC,
    output logic [31:0] m_alu,
    output logic [31:0] m_sd
);
    logic [4:0]  r1, r2;
    logic        v1, v2, m_wr, wb_wr, m_hit1, m_hit2, wb_hit1, wb_hit2, go, take, unused_ok;
    logic [31:0] a_f, b_f, sd_f, alu;
    logic        m_running_d, m_running_q, m_WEn_d, m_WEn_q, m_RFWr_d, m_RFWr_q;
    logic [1:0]  m_WDSel_d, m_WDSel_q;
    logic [4:0]  m_wR_d, m_wR_q;
    logic [31:0] m_PC_d, m_PC_q, m_alu_d, m_alu_q, m_sd_d, m_sd_q;

    assign r1      = id.rR1[4:0];
    assign r2      = id.rR2[4:0];
    assign v1      = id.rR1 != '1;
    assign v2      = id.rR2 != '1;
    assign m_wr    = m_running & m_RFWr & (m_wR != 5'd0);
    assign wb_wr   = wb_RFWr & (wb_wR != 5'd0);
    assign m_hit1  = m_wr & (m_wR == r1);
    assign m_hit2  = m_wr & (m_wR == r2);
    assign wb_hit1 = wb_wr & (wb_wR == r1);
    assign wb_hit2 = wb_wr & (wb_wR == r2);

`ifdef EX_FWD_EN
    logic        m_fwd;
    logic [31:0] m_val;
    // a load in EX/MEM has no data yet, so it is never a forwarding source
    assign m_fwd    = m_WDSel != 2'b01;
    assign m_val    = m_WDSel == 2'b10 ? m_PC + 32'd4 : m_alu;
    assign a_f      = v1 & m_fwd & m_hit1 ? m_val : v1 & wb_hit1 ? wb_wD : id.A;
    assign b_f      = v2 & m_fwd & m_hit2 ? m_val : v2 & wb_hit2 ? wb_wD : id.B;
    assign sd_f     = m_fwd & m_hit2 ? m_val : wb_hit2 ? wb_wD : id.rD2;
    assign id.stall = id.running & (m_WDSel == 2'b01) & (v1 & m_hit1 | v2 & m_hit2);
    assign unused_ok = ^id.wR[31:5];
`else
    assign a_f      = id.A;
    assign b_f      = id.B;
    assign sd_f     = id.rD2;
    assign id.stall = id.running & (v1 & (m_hit1 | wb_hit1) | v2 & (m_hit2 | wb_hit2));
    assign unused_ok = ^{id.wR[31:5], wb_wD};
`endif

    always_comb begin
        alu = '0;
        case (id.ALUop)
            4'd0:  alu = a_f + b_f;
            4'd1:  alu = a_f - b_f;
            4'd2:  alu = a_f & b_f;
            4'd3:  alu = a_f | b_f;
            4'd4:  alu = a_f ^ b_f;
            4'd5:  alu = a_f << b_f[4:0];
            4'd6:  alu = a_f >> b_f[4:0];
            4'd7:  alu = $unsigned($signed(a_f) >>> b_f[4:0]);
            4'd8:  alu = {31'd0, $signed(a_f) < $signed(b_f)};
            4'd9:  alu = {31'd0, a_f < b_f};
            4'd10: alu = b_f;
            4'd11: alu = {31'd0, a_f == b_f};
            4'd12: alu = {31'd0, a_f != b_f};
            4'd13: alu = {31'd0, $signed(a_f) >= $signed(b_f)};
            4'd14: alu = {31'd0, a_f >= b_f};
            default: alu = '0;
        endcase
    end

    assign take      = id.running & !id.stall & (id.NPCop[1] | (id.NPCop == 2'b01) & alu[0]);
    assign id.branch = take;
    assign id.npc    = !take ? id.PC + 32'd4 :
                       id.NPCop == 2'b11 ? (a_f + id.ext) & ~32'd1 : id.PC + id.ext;

    // stalled or idle slots enter EX/MEM as an all-zero bubble
    always_comb begin
        go          = id.running & !id.stall;
        m_running_d = go;
        m_WEn_d     = go & id.WEn;
        m_RFWr_d    = go & id.RFWr;
        m_WDSel_d   = go ? id.WDSel : 2'b0;
        m_wR_d      = go ? id.wR[4:0] : 5'b0;
        m_PC_d      = go ? id.PC : '0;
        m_alu_d     = go ? alu : '0;
        m_sd_d      = go ? sd_f : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            m_running_q <= 1'b0;
            m_WEn_q     <= 1'b0;
            m_RFWr_q    <= 1'b0;
            m_WDSel_q   <= '0;
            m_wR_q      <= '0;
            m_PC_q      <= '0;
            m_alu_q     <= '0;
            m_sd_q      <= '0;
        end else begin
            m_running_q <= m_running_d;
            m_WEn_q     <= m_WEn_d;
            m_RFWr_q    <= m_RFWr_d;
            m_WDSel_q   <= m_WDSel_d;
            m_wR_q      <= m_wR_d;
            m_PC_q      <= m_PC_d;
            m_alu_q     <= m_alu_d;
            m_sd_q      <= m_sd_d;
        end
    end

    assign m_running = m_running_q;
    assign m_WEn     = m_WEn_q;
    assign m_RFWr    = m_RFWr_q;
    assign m_WDSel   = m_WDSel_q;
    assign m_wR      = m_wR_q;
    assign m_PC      = m_PC_q;
    assign m_alu     = m_alu_q;
    assign m_sd      = m_sd_q;
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed vectors; registered outputs checked through a scoreboard queue
module tb_ex_mem_stage;
    localparam logic [31:0] NR = 32'hFFFF_FFFF;

    typedef struct {
        string       nm;
        logic        run, wen, rfwr;
        logic [1:0]  ws;
        logic [4:0]  wr;
        logic [31:0] pc, alu, sd;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b0;
    logic        wb_RFWr = 1'b0;
    logic [4:0]  wb_wR = '0;
    logic [31:0] wb_wD = '0;
    logic        m_running, m_WEn, m_RFWr;
    logic [1:0]  m_WDSel;
    logic [4:0]  m_wR;
    logic [31:0] m_PC, m_alu, m_sd;
    int          n_chk = 0, n_fail = 0;
    exp_t        q[$];
    logic [31:0] alu_tbl [16] = '{32'hF000000C, 32'hF0000004, 32'h0, 32'hF000000C,
                                  32'hF000000C, 32'h00000080, 32'h0F000000, 32'hFF000000,
                                  32'h1, 32'h0, 32'h4, 32'h0, 32'h1, 32'h0, 32'h1, 32'h0};

    ex_mem_if bus();

    ex_mem_stage dut (
        .clk(clk), .rst(rst), .id(bus),
        .wb_RFWr(wb_RFWr), .wb_wR(wb_wR), .wb_wD(wb_wD),
        .m_running(m_running), .m_WEn(m_WEn), .m_RFWr(m_RFWr), .m_WDSel(m_WDSel),
        .m_wR(m_wR), .m_PC(m_PC), .m_alu(m_alu), .m_sd(m_sd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    function automatic exp_t ex(input logic run, wen, rfwr, input logic [1:0] ws,
                                input logic [4:0] wr, input logic [31:0] pc, alu, sd);
        ex.nm = ""; ex.run = run; ex.wen = wen; ex.rfwr = rfwr; ex.ws = ws;
        ex.wr = wr; ex.pc = pc; ex.alu = alu; ex.sd = sd;
    endfunction

    function automatic exp_t zb();
        return ex(0, 0, 0, 2'd0, 5'd0, 0, 0, 0);
    endfunction

    task automatic drv(input logic run, input logic [1:0] npcop, input logic wen, rfwr,
                       input logic [1:0] ws, input logic [3:0] op,
                       input logic [31:0] pc, a, b, rd2, ext, r1, r2, wr);
        bus.running = run; bus.NPCop = npcop; bus.WEn = wen; bus.RFWr = rfwr;
        bus.WDSel = ws; bus.ALUop = op; bus.PC = pc; bus.A = a; bus.B = b;
        bus.rD2 = rd2; bus.ext = ext; bus.rR1 = r1; bus.rR2 = r2; bus.wR = wr;
    endtask

    // checks the combinational outputs now, queues the registered expectation, advances one cycle
    task automatic step(input string nm, input logic s, input logic br,
                        input logic [31:0] np, input exp_t e);
        #1;
        chk({nm, ".stall"}, {31'd0, bus.stall}, {31'd0, s});
        chk({nm, ".branch"}, {31'd0, bus.branch}, {31'd0, br});
        chk({nm, ".npc"}, bus.npc, np);
        e.nm = nm;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    // without forwarding, a dependent op waits on EX/MEM and then on write-back
    task automatic hold(input string nm, input logic [4:0] r, input logic [31:0] d);
`ifndef EX_FWD_EN
        step({nm, "_s1"}, 1, 0, bus.PC + 32'd4, zb());
        wb_RFWr = 1; wb_wR = r; wb_wD = d;
        step({nm, "_s2"}, 1, 0, bus.PC + 32'd4, zb());
        wb_RFWr = 0;
`else
        if (r == 5'd31 && d == 32'd0) $display("hold %s", nm);
`endif
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk({e.nm, ".ctrl"}, {22'd0, m_running, m_WEn, m_RFWr, m_WDSel, m_wR},
                    {22'd0, e.run, e.wen, e.rfwr, e.ws, e.wr});
                chk({e.nm, ".m_PC"}, m_PC, e.pc);
                chk({e.nm, ".m_alu"}, m_alu, e.alu);
                chk({e.nm, ".m_sd"}, m_sd, e.sd);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : driver
        drv(1, 0, 0, 1, 0, 0, 'h10, 5, 7, 0, 0, NR, NR, 1);
        @(posedge clk);
        @(negedge clk);
        step("rst", 0, 0, 'h14, zb());
        rst = 1;
        drv(1, 0, 0, 1, 0, 0, 'h20, 5, 7, 0, 0, NR, NR, 1);
        step("add", 0, 0, 'h24, ex(1, 0, 1, 0, 1, 'h20, 12, 0));
        drv(1, 0, 0, 1, 0, 1, 'h24, 0, 2, 0, 0, 1, NR, 2);
        hold("sub", 1, 12);
`ifndef EX_FWD_EN
        bus.A = 12;
`endif
        step("sub", 0, 0, 'h28, ex(1, 0, 1, 0, 2, 'h24, 10, 0));
        drv(1, 0, 0, 1, 1, 0, 'h30, 'h100, 0, 0, 0, NR, NR, 3);
        step("ld", 0, 0, 'h34, ex(1, 0, 1, 1, 3, 'h30, 'h100, 0));
        drv(1, 1, 0, 1, 0, 0, 'h34, 0, 5, 0, 'h10, 3, NR, 4);
        step("ldu_s", 1, 0, 'h38, zb());
        wb_RFWr = 1; wb_wR = 3; wb_wD = 'h40;
`ifndef EX_FWD_EN
        step("ldu_s2", 1, 0, 'h38, zb());
        wb_RFWr = 0;
        bus.A = 'h40;
`endif
        step("ldu", 0, 1, 'h44, ex(1, 0, 1, 0, 4, 'h34, 'h45, 0));
        wb_RFWr = 0;
        drv(1, 1, 0, 0, 0, 11, 'h100, 9, 9, 0, 'h20, NR, NR, 0);
        step("beq_t", 0, 1, 'h120, ex(1, 0, 0, 0, 0, 'h100, 1, 0));
        bus.B = 8;
        step("beq_n", 0, 0, 'h104, ex(1, 0, 0, 0, 0, 'h100, 0, 0));
        drv(1, 3, 0, 1, 2, 0, 'h200, 'h203, 0, 0, 4, NR, NR, 5);
        step("jalr", 0, 1, 'h206, ex(1, 0, 1, 2, 5, 'h200, 'h203, 0));
        drv(1, 0, 0, 1, 0, 0, 'h204, 0, 1, 0, 0, 5, NR, 6);
        hold("jdep", 5, 'h204);
`ifndef EX_FWD_EN
        bus.A = 'h204;
`endif
        step("jdep", 0, 0, 'h208, ex(1, 0, 1, 0, 6, 'h204, 'h205, 0));
        drv(0, 2, 1, 1, 2, 3, 'h300, 3, 4, 5, 6, 5, 5, 7);
        step("bub", 0, 0, 'h304, zb());
        drv(1, 0, 0, 1, 0, 0, 'h310, 1, 1, 0, 0, NR, NR, 0);
        step("x0w", 0, 0, 'h314, ex(1, 0, 1, 0, 0, 'h310, 2, 0));
        drv(1, 0, 0, 1, 0, 0, 'h314, 'h55, 0, 0, 0, 0, NR, 8);
        wb_RFWr = 1; wb_wR = 0; wb_wD = 'hDEAD;
        step("x0r", 0, 0, 'h318, ex(1, 0, 1, 0, 8, 'h314, 'h55, 0));
        wb_RFWr = 0;
        drv(1, 0, 1, 0, 0, 0, 'h318, 'h300, 0, 0, 0, NR, 8, 0);
        hold("st", 8, 'h55);
`ifndef EX_FWD_EN
        bus.B = 'h55; bus.rD2 = 'h55;
`endif
        step("st", 0, 0, 'h31C, ex(1, 1, 0, 0, 0, 'h318, 'h355, 'h55));
        drv(1, 0, 0, 1, 1, 0, 'h400, 'h10, 0, 0, 0, NR, NR, 9);
        step("ld9", 0, 0, 'h404, ex(1, 0, 1, 1, 9, 'h400, 'h10, 0));
        drv(1, 0, 0, 1, 0, 0, 'h404, 7, 1, 0, 0, 9, NR, 10);
        rst = 0;
        step("rst_st", 1, 0, 'h408, zb());
        rst = 1;
        step("after", 0, 0, 'h408, ex(1, 0, 1, 0, 10, 'h404, 8, 0));
        for (int i = 0; i < 16; i++) begin
            drv(1, 0, 0, 0, 0, 4'(i), 'h500 + 32'(i) * 4, 'hF0000008, 4, 0, 0, NR, NR, 0);
            step($sformatf("alu%0d", i), 0, 0, 'h504 + 32'(i) * 4,
                 ex(1, 0, 0, 0, 0, 'h500 + 32'(i) * 4, alu_tbl[i], 0));
        end
        bus.running = 0;
        @(negedge clk);
        chk("drain", 32'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute stage plus EX/MEM pipeline register, directly downstream of the ID/EX latch in the five-stage core. Consumes the latched decode bundle (`running`, `NPCop`, `ALUop`, `A`/`B`, `rR1`/`rR2`, `rD2`, `wR`, `ext`, `PC`), resolves operand forwarding and load-use hazards, computes the ALU result, and decides branches/jumps. It registers the result bundle for the memory stage. Branch outputs drive the `branch` flush input of the IF/ID and ID/EX latches.

## Interface
- No parameters. Data width is fixed at 32.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: reset, synchronous, active-low.
- `running` in 1: ID/EX bundle valid.
- `NPCop` in 2: next-PC op. 00 sequential, 01 conditional branch, 10 jal, 11 jalr.
- `WEn`, `RFWr` in 1 each: memory write enable; register-file write enable.
- `WDSel` in 2: write-back select. 00 ALU, 01 load, 10 PC+4.
- `ALUop` in 4: ALU operation.
- `PC`, `A`, `B`, `rD2`, `ext` in 32 each: PC; operand A; operand B; store data; immediate.
- `rR1`, `rR2` in 32: source register index. All-ones (-1) means the operand is not a register read and is never forwarded or stalled on.
- `wR` in 32: destination index. Only bits [4:0] are used.
- `wb_RFWr` in 1, `wb_wR` in 5, `wb_wD` in 32: write-back stage write port, used as a forwarding source.
- `stall` out 1: combinational load-use hold request to IF/IF-ID/ID-EX.
- `branch` out 1, `npc` out 32: combinational redirect pulse and target.
- `m_running`, `m_WEn`, `m_RFWr` out 1 each; `m_WDSel` out 2; `m_wR` out 5: registered control bundle.
- `m_PC`, `m_alu`, `m_sd` out 32 each: registered PC, ALU result, and forwarded store data.

## Operation
- **Forwarding priority, per operand:**
  - EX/MEM register first. Condition: `m_running & m_RFWr & m_wR!=0 & m_wR==rRx[4:0] & m_WDSel!=01`. Value: `m_alu`, or `m_PC+4` when `m_WDSel==10`.
  - Write-back second. Condition: `wb_RFWr & wb_wR!=0 & match`. Value: `wb_wD`.
  - Otherwise the ID/EX value.
- **Forwarded operands:**
  - `rR1` forwards into `A`.
  - `rR2` forwards into `B` and `rD2`. When `rR2==-1`, `rD2` is still forwarded by its index in `rR2in`; ID sets `rR2` to -1 only for immediate-B non-stores.
- **Load-use:** `stall=1` when `running & m_running & m_RFWr & m_WDSel==01 & m_wR!=0` and `m_wR` matches a non-(-1) `rR1` or `rR2`.
  - On stall, the EX/MEM register loads a bubble (all outputs zero). The input bundle is held upstream and re-presented next cycle.
- **ALUop encoding:**
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA, all using shift amount `B[4:0]`.
  - 8 SLT (signed), 9 SLTU, 10 pass B.
  - 11 EQ, 12 NE, 13 GE (signed), 14 GEU.
  - 15 yields 0.
  - Compare ops return 32'd0 or 32'd1. Add/sub wrap modulo 2^32.
- **Branch decision:** `branch=1` only when `running & !stall` and one of:
  - `NPCop==01` and `alu[0]==1`: target `PC+ext`.
  - `NPCop==10`: target `PC+ext`.
  - `NPCop==11`: target `(A_fwd+ext) & ~1`.
  - Otherwise `branch=0` and `npc=PC+4`.
- **Normal register update:** when `!stall`, the EX/MEM register loads
  - `m_running<=running`,
  - the control and data fields when `running=1`,
  - all zeros when `running=0`, so a bubble never writes.
- **Branch instruction itself:** it is not flushed. Its own EX/MEM entry is kept, so jal/jalr link writes proceed.

## Timing
- Reset: while `rst==0` at posedge, every `m_*` output is 0. `stall`, `branch` and `npc` follow their combinational inputs; with `m_running=0`, `stall=0`.
- Latency: one cycle from ID/EX output to `m_*`.
- `branch`/`npc` are valid in the same cycle as the ID/EX output. Upstream flushes on the next posedge, giving a 2-instruction penalty.
- Load-use costs 1 bubble. The retried instruction forwards from write-back on the following cycle.
- Simultaneous stall and branch-qualifying inputs: `stall` wins and `branch=0`; the branch resolves on the retry.
- Reset asserted mid-stall: the register clears. `stall` drops because `m_running=0`.
- Register 0 is never a forwarding match.

## Configuration
- `EX_FWD_EN` defined: both forwarding paths are active as above.
- `EX_FWD_EN` undefined:
  - No forwarding; operands are always the ID/EX values.
  - `stall` asserts on any match of a non-(-1) source index with a writing, nonzero `m_wR` (any `WDSel`) or `wb_wR`.
  - Bubble insertion rules are unchanged.

## Test plan
- Reset: `rst=0` with `running=1`, ADD bundle -> all `m_*`=0, `m_running=0`.
- EX->EX forward, ADD x1=5+7 then SUB x2=x1-2 -> second cycle `m_alu=12` then `m_alu=10`, `stall=0`. Without `EX_FWD_EN`: `stall=1` for 2 cycles, then result 10.
- Load-use: load to x3 then ADD using x3 -> one cycle `stall=1` with `m_running=0`; retry with `wb_wD=0x40` gives `m_alu=0x40+B`.
- Branch: `NPCop=01`, ALUop EQ, `A=B=9`, `PC=0x100`, `ext=0x20` -> `branch=1`, `npc=0x120`. With `A=9`, `B=8` -> `branch=0`, `npc=0x104`.
- jalr: `A=0x203`, `ext=4`, `WDSel=10` -> `npc=0x206`, `m_RFWr=1` registered; the following dependent ADD sees forwarded `PC+4`.
- Bubble: `running=0` with nonzero fields -> `m_*`=0, `branch=0`; the x0 destination is never forwarded.
